// File: rtl/eq_i2s_tx_if.sv
//==============================================================================
// Module  : eq_i2s_tx_if
// Brief   : valid/ready sample stream from the equalizer into the I2S output stage
// Revision: 1.0  initial release
//==============================================================================
`default_nettype none

interface eq_i2s_tx_if #(
    parameter int DATA_WIDTH = 24
);
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_valid;
    logic                  s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

`default_nettype wire

// File: rtl/eq_i2s_tx.sv
//==============================================================================
// Module  : eq_i2s_tx
// Brief   : FIFO-buffered Philips I2S transmitter, mono sample on both slots.
//           Define I2S_TX_STATUS_EN to add the saturating underrun_count port.
// Revision: 1.0  initial release
//==============================================================================
`default_nettype none

module eq_i2s_tx #(
    parameter int DATA_WIDTH = 24,
    parameter int CLK_DIV    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic                      clk,
    input  wire logic                      rst,
    eq_i2s_tx_if.slave                     s,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
    output logic                           i2s_sclk,
    output logic                           i2s_lrclk,
    output logic                           i2s_sdata,
    output logic                           underrun
`ifdef I2S_TX_STATUS_EN
    ,
    output logic [15:0]                    underrun_count
`endif
);

    localparam int              AW         = $clog2(FIFO_DEPTH);
    localparam int              LW         = AW + 1;
    localparam int              CW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0]   DIV_MAX    = CW'(CLK_DIV - 1);
    localparam logic [LW-1:0]   LEVEL_FULL = LW'(FIFO_DEPTH);

    logic [CW-1:0]          div_cnt_q, div_cnt_d;
    logic                   sclk_q, sclk_d;
    logic [5:0]             p_q, p_d;
    logic                   lrclk_q;
    logic                   sdata_q, sdata_d;
    logic                   underrun_q, underrun_d;
    logic [DATA_WIDTH-1:0]  tx_q, tx_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]          level_q, level_d;
    logic [DATA_WIDTH-1:0]  mem_q [FIFO_DEPTH];

    logic                   w_tick;
    logic                   w_fall;
    logic                   w_load;
    logic                   w_empty;
    logic                   w_ready;
    logic                   w_push;
    logic                   w_pop;
    logic [4:0]             w_slot;
    logic                   w_bit;

    // Ready depends only on registered level so a pop never feeds back combinationally.
    assign w_ready   = (level_q != LEVEL_FULL);
    assign s.s_ready = w_ready;

    always_comb begin
        w_tick    = (div_cnt_q == DIV_MAX);
        div_cnt_d = w_tick ? '0 : div_cnt_q + 1'b1;
        sclk_d    = w_tick ? ~sclk_q : sclk_q;
        w_fall    = w_tick & sclk_q;
        w_load    = w_fall & (p_q == 6'd63);
        w_empty   = (level_q == '0);
        w_pop     = w_load & ~w_empty;
        w_push    = s.s_valid & w_ready;

        p_d = w_fall ? p_q + 6'd1 : p_q;

        tx_d = tx_q;
        if (w_load) begin
            tx_d = w_pop ? mem_q[rd_ptr_q] : '0;
        end
        underrun_d = w_load & w_empty;

        // Slot bit s carries tx[DATA_WIDTH-s]; s=0 is the one-bit I2S delay.
        w_slot = p_d[4:0];
        w_bit  = 1'b0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (5'(DATA_WIDTH - i) == w_slot) begin
                w_bit = tx_d[i];
            end
        end
        sdata_d = w_fall ? w_bit : sdata_q;

        wr_ptr_d = w_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = w_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({w_push, w_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q  <= '0;
            sclk_q     <= 1'b0;
            p_q        <= 6'd63;
            lrclk_q    <= 1'b0;
            sdata_q    <= 1'b0;
            underrun_q <= 1'b0;
            tx_q       <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
        end else begin
            div_cnt_q  <= div_cnt_d;
            sclk_q     <= sclk_d;
            p_q        <= p_d;
            lrclk_q    <= p_d[5];
            sdata_q    <= sdata_d;
            underrun_q <= underrun_d;
            tx_q       <= tx_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
        end
    end

    // Storage needs no reset: pointers and level define which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= s.s_data;
        end
    end

`ifdef I2S_TX_STATUS_EN
    logic [15:0] ucnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ucnt_q <= '0;
        end else if (underrun_d && (ucnt_q != 16'hFFFF)) begin
            ucnt_q <= ucnt_q + 16'd1;
        end
    end

    assign underrun_count = ucnt_q;
`endif

    assign fifo_level = level_q;
    assign i2s_sclk   = sclk_q;
    assign i2s_lrclk  = lrclk_q;
    assign i2s_sdata  = sdata_q;
    assign underrun   = underrun_q;

endmodule

`default_nettype wire

// File: tb/tb_eq_i2s_tx.sv
//==============================================================================
// Module  : tb_eq_i2s_tx
// Brief   : directed bench for eq_i2s_tx at default parameters (frame = 512 clk)
// Revision: 1.0  initial release
//==============================================================================
`default_nettype none

module tb_eq_i2s_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] fifo_level;
    logic       i2s_sclk, i2s_lrclk, i2s_sdata, underrun;
`ifdef I2S_TX_STATUS_EN
    logic [15:0] underrun_count;
`endif

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    eq_i2s_tx_if #(.DATA_WIDTH(24)) bus ();

    eq_i2s_tx #(
        .DATA_WIDTH (24),
        .CLK_DIV    (4),
        .FIFO_DEPTH (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .s              (bus),
        .fifo_level     (fifo_level),
        .i2s_sclk       (i2s_sclk),
        .i2s_lrclk      (i2s_lrclk),
        .i2s_sdata      (i2s_sdata),
        .underrun       (underrun)
`ifdef I2S_TX_STATUS_EN
        ,
        .underrun_count (underrun_count)
`endif
    );

    always #5 clk = ~clk;

    // cyc = index of the last rising edge since reset release
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_cyc(input int n);
        if (cyc > n) begin
            n_vec++; n_err++;
            $display("FAIL wait_cyc: cycle %0d already passed (now %0d)", n, cyc);
        end
        while (cyc < n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic push_one(input logic [23:0] w);
        bus.s_valid = 1'b1;
        bus.s_data  = w;
        @(negedge clk);
        bus.s_valid = 1'b0;
    endtask

    // Frame f starts on the load edge at clk 8+512*f; bit p is held from clk 8+512*f+8*p.
    task automatic check_frame(input int f, input logic [23:0] w, input logic exp_ur,
                               input string name);
        logic [31:0] slot;
        logic [63:0] exp_d, exp_lr, got_d, got_lr;
        logic        ur0, ur1;
        int          base;
        base   = 8 + 512 * f;
        slot   = {1'b0, w, 7'b0};
        exp_d  = {slot, slot};
        exp_lr = {32'h0000_0000, 32'hFFFF_FFFF};
        ur0 = 1'b0; ur1 = 1'b0;
        for (int p = 0; p < 64; p++) begin
            wait_cyc(base + 8 * p);
            got_d[63-p]  = i2s_sdata;
            got_lr[63-p] = i2s_lrclk;
            if (p == 0) begin
                ur0 = underrun;
                wait_cyc(base + 1);
                ur1 = underrun;
            end
        end
        n_vec++;
        if (got_d !== exp_d) begin
            n_err++;
            $display("FAIL %s sdata: got %h expected %h", name, got_d, exp_d);
        end
        n_vec++;
        if (got_lr !== exp_lr) begin
            n_err++;
            $display("FAIL %s lrclk: got %h expected %h", name, got_lr, exp_lr);
        end
        n_vec++;
        if (ur0 !== exp_ur) begin
            n_err++;
            $display("FAIL %s underrun at load: got %b expected %b", name, ur0, exp_ur);
        end
        n_vec++;
        if (ur1 !== 1'b0) begin
            n_err++;
            $display("FAIL %s underrun width: got %b expected 0 one clk later", name, ur1);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({i2s_sclk, i2s_lrclk, i2s_sdata, underrun} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset outputs: got %b expected 0000",
                     {i2s_sclk, i2s_lrclk, i2s_sdata, underrun});
        end
        n_vec++;
        if (fifo_level !== 3'd0 || bus.s_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset fifo: level %0d ready %b expected 0 / 1", fifo_level, bus.s_ready);
        end
`ifdef I2S_TX_STATUS_EN
        n_vec++;
        if (underrun_count !== 16'd0) begin
            n_err++;
            $display("FAIL reset count: got %0d expected 0", underrun_count);
        end
`endif
        rst = 1'b0;
        wait_cyc(3);
        n_vec++;
        if (i2s_sclk !== 1'b0) begin
            n_err++; $display("FAIL sclk clk3: got %b expected 0", i2s_sclk);
        end
        wait_cyc(4);
        n_vec++;
        if (i2s_sclk !== 1'b1) begin
            n_err++; $display("FAIL sclk clk4: got %b expected 1", i2s_sclk);
        end
        wait_cyc(8);
        n_vec++;
        if (i2s_sclk !== 1'b0) begin
            n_err++; $display("FAIL sclk clk8: got %b expected 0", i2s_sclk);
        end
    endtask

    task automatic test_basic_frame();
        do_reset();
        push_one(24'hA50F3C);
        n_vec++;
        if (fifo_level !== 3'd1) begin
            n_err++; $display("FAIL basic level after push: got %0d expected 1", fifo_level);
        end
        check_frame(0, 24'hA50F3C, 1'b0, "basic f0");
        n_vec++;
        if (fifo_level !== 3'd0) begin
            n_err++; $display("FAIL basic level after load: got %0d expected 0", fifo_level);
        end
        check_frame(1, 24'h000000, 1'b1, "basic f1");
    endtask

    task automatic test_underrun();
        do_reset();
        wait_cyc(7);
        n_vec++;
        if (underrun !== 1'b0) begin
            n_err++; $display("FAIL underrun early: got %b expected 0", underrun);
        end
        check_frame(0, 24'h000000, 1'b1, "underrun f0");
`ifdef I2S_TX_STATUS_EN
        n_vec++;
        if (underrun_count !== 16'd1) begin
            n_err++; $display("FAIL underrun count: got %0d expected 1", underrun_count);
        end
`endif
    endtask

    task automatic test_back_to_back();
        logic saw_full;
        saw_full = 1'b0;
        do_reset();
        fork
            begin
                for (int v = 1; v <= 6; v++) begin
                    int  n;
                    logic r;
                    n = 0;
                    bus.s_valid = 1'b1;
                    bus.s_data  = 24'(v);
                    forever begin
                        r = bus.s_ready;
                        if (fifo_level == 3'd4 && !r) saw_full = 1'b1;
                        @(negedge clk);
                        n++;
                        if (r) break;
                        if (n > 5000) begin
                            n_vec++; n_err++;
                            $display("FAIL stream stall on sample %0d: ready never high", v);
                            break;
                        end
                    end
                end
                bus.s_valid = 1'b0;
            end
            begin
                for (int f = 0; f < 6; f++) begin
                    check_frame(f, 24'(f + 1), 1'b0, "stream");
                end
            end
        join
        n_vec++;
        if (saw_full !== 1'b1) begin
            n_err++; $display("FAIL stream backpressure: got %b expected ready low at level 4", saw_full);
        end
        n_vec++;
        if (fifo_level !== 3'd0) begin
            n_err++; $display("FAIL stream drained level: got %0d expected 0", fifo_level);
        end
    endtask

    task automatic test_extremes();
        do_reset();
        push_one(24'h800000);
        push_one(24'h7FFFFF);
        check_frame(0, 24'h800000, 1'b0, "most negative");
        check_frame(1, 24'h7FFFFF, 1'b0, "most positive");
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        push_one(24'h111111);
        push_one(24'h222222);
        push_one(24'h333333);
        push_one(24'h444444);
        wait_cyc(8 + 8 * 40);
        n_vec++;
        if (fifo_level !== 3'd3 || i2s_lrclk !== 1'b1) begin
            n_err++;
            $display("FAIL midreset pre: level %0d lrclk %b expected 3 / 1", fifo_level, i2s_lrclk);
        end
        rst = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({i2s_sclk, i2s_lrclk, i2s_sdata, underrun} !== 4'b0000) begin
            n_err++;
            $display("FAIL midreset outputs: got %b expected 0000",
                     {i2s_sclk, i2s_lrclk, i2s_sdata, underrun});
        end
        n_vec++;
        if (fifo_level !== 3'd0 || bus.s_ready !== 1'b1) begin
            n_err++;
            $display("FAIL midreset fifo: level %0d ready %b expected 0 / 1", fifo_level, bus.s_ready);
        end
`ifdef I2S_TX_STATUS_EN
        n_vec++;
        if (underrun_count !== 16'd0) begin
            n_err++; $display("FAIL midreset count: got %0d expected 0", underrun_count);
        end
`endif
        rst = 1'b0;
        check_frame(0, 24'h000000, 1'b1, "after midreset");
    endtask

    task automatic test_push_on_load();
        do_reset();
        wait_cyc(7);
        push_one(24'h123456);
        n_vec++;
        if (fifo_level !== 3'd1) begin
            n_err++; $display("FAIL loadpush level: got %0d expected 1", fifo_level);
        end
        check_frame(0, 24'h000000, 1'b1, "loadpush f0");
        check_frame(1, 24'h123456, 1'b0, "loadpush f1");
    endtask

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        test_reset();
        test_basic_frame();
        test_underrun();
        test_back_to_back();
        test_extremes();
        test_reset_mid_frame();
        test_push_on_load();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
